// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the decoder.
// Owns the PC, issues one word read at a time to instruction memory, holds the
// returned instruction for decode, and handles execute-stage redirects by
// dropping any stale in-flight fetch.
// Optional: define IFU_MISALIGN_CHK_EN to trap misaligned redirect targets into
// a terminal fault state; otherwise the low target bits are cleared.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h80000000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_DROP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h00000013;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [XLEN-1:0]   redirect_tgt;
  logic              req_fire;
  logic              load_out;

  // Request is gated while reset is held so nothing is issued before release.
  assign imem_req_valid = (state == S_REQ) && !halt_req && !rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_valid      = (state == S_OUT);
  assign out_opcode     = out_inst[6:0];
  assign out_funct3     = out_inst[14:12];
  assign out_funct7     = out_inst[30];

  // Word-align the redirect target; with the checker enabled a misaligned
  // target never reaches the PC, so the mask is harmless there too.
  assign redirect_tgt   = redirect_pc & ~XLEN'(3);

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign;
  logic fault_set;
  logic fault_q;
  assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Next-state, next-PC and latch-enable decode; redirect overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_next = state;
    pc_next    = pc;
    load_out   = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    fault_set  = 1'b0;
`endif
    case (state)
      S_REQ:   if (req_fire) state_next = S_WAIT;
      S_WAIT:  if (imem_resp_valid) begin
                 state_next = S_OUT;
                 load_out   = 1'b1;
               end
      S_OUT:   if (out_ready) begin
                 state_next = S_REQ;
                 pc_next    = pc + XLEN'(4);
               end
      S_DROP:  if (imem_resp_valid) state_next = S_REQ;
      default: state_next = state;  // S_FAULT is terminal
    endcase

    if (redirect_valid && state != S_FAULT) begin
      pc_next  = redirect_tgt;
      load_out = 1'b0;
      case (state)
        S_REQ:   state_next = req_fire        ? S_DROP : S_REQ;
        S_WAIT:  state_next = imem_resp_valid ? S_REQ  : S_DROP;
        S_OUT:   state_next = S_REQ;
        S_DROP:  state_next = imem_resp_valid ? S_REQ  : S_DROP;
        default: state_next = state;
      endcase
`ifdef IFU_MISALIGN_CHK_EN
      if (misalign) begin
        state_next = S_FAULT;
        pc_next    = pc;
        fault_set  = 1'b1;
      end
`endif
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update from the same pre-edge values.
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Instruction/PC holding register presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_inst <= NOP;
      out_pc   <= RESET_PC;
    end else if (load_out) begin
      out_inst <= imem_resp_data;
      out_pc   <= pc;
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch; the memory side is driven by hand
// step by step with hand-computed expectations.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7;
  logic        fetch_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_opcode     (out_opcode),
    .out_funct3     (out_funct3),
    .out_funct7     (out_funct7),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs return to idle, caller then drives this cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    out_ready       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h00000013);
    check("rst_out_pc", out_pc, 32'h80000000);
    check("rst_opcode", {25'b0, out_opcode}, 32'h13);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    rst = 1'b0;

    // First fetch, zero-wait memory
    imem_req_ready = 1'b1;
    #1;
    check("f0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("f0_req_addr", imem_req_addr, 32'h80000000);
    next_cycle();  // S_WAIT
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00100093;
    #1;
    check("f0_wait_req", {31'b0, imem_req_valid}, 32'd0);
    check("f0_wait_outv", {31'b0, out_valid}, 32'd0);
    next_cycle();  // S_OUT
    #1;
    check("f0_out_valid", {31'b0, out_valid}, 32'd1);
    check("f0_out_inst", out_inst, 32'h00100093);
    check("f0_opcode", {25'b0, out_opcode}, 32'h13);
    check("f0_funct3", {29'b0, out_funct3}, 32'd0);
    check("f0_funct7", {31'b0, out_funct7}, 32'd0);
    check("f0_out_pc", out_pc, 32'h80000000);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      imem_req_ready = 1'b1;
      #1;
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_pc", out_pc, 32'h80000000);
      check("stall_out_inst", out_inst, 32'h00100093);
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    end
    out_ready = 1'b1;
    next_cycle();  // S_REQ, pc+4
    imem_req_ready = 1'b1;
    #1;
    check("f1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("f1_req_addr", imem_req_addr, 32'h80000004);
    check("f1_out_valid", {31'b0, out_valid}, 32'd0);

    // Redirect while waiting; response arrives two cycles later and is dropped
    next_cycle();  // S_WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h80000100;
    next_cycle();  // S_DROP
    #1;
    check("drop_req_valid", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
    #1;
    check("drop_out_valid", {31'b0, out_valid}, 32'd0);
    next_cycle();  // S_REQ at redirect target
    imem_req_ready = 1'b1;
    #1;
    check("rd_out_valid", {31'b0, out_valid}, 32'd0);
    check("rd_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("rd_req_addr", imem_req_addr, 32'h80000100);
    next_cycle();  // S_WAIT
    imem_resp_valid = 1'b1; imem_resp_data = 32'h4020D133;  // sra x2,x1,x2
    next_cycle();  // S_OUT
    #1;
    check("f2_out_valid", {31'b0, out_valid}, 32'd1);
    check("f2_out_pc", out_pc, 32'h80000100);
    check("f2_out_inst", out_inst, 32'h4020D133);
    check("f2_opcode", {25'b0, out_opcode}, 32'h33);
    check("f2_funct3", {29'b0, out_funct3}, 32'd5);
    check("f2_funct7", {31'b0, out_funct7}, 32'd1);

    // Redirect coincident with decode accept: target wins over pc+4
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80000200;
    next_cycle();
    #1;
    check("ra_out_valid", {31'b0, out_valid}, 32'd0);
    check("ra_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("ra_req_addr", imem_req_addr, 32'h80000200);

    // Halt in S_REQ for 4 cycles, memory ready throughout
    for (int i = 0; i < 4; i++) begin
      if (i != 0) next_cycle();
      halt_req = 1'b1; imem_req_ready = 1'b1;
      #1;
      check("halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("halt_req_addr", imem_req_addr, 32'h80000200);
    end
    next_cycle();
    halt_req = 1'b0;
    #1;
    check("unhalt_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("unhalt_req_addr", imem_req_addr, 32'h80000200);

    // Redirect with handshake in the same cycle -> stale request dropped
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    next_cycle();  // S_DROP
    #1;
    check("hsr_req_valid", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h12345678;
    next_cycle();  // S_REQ
    imem_req_ready = 1'b1;
    #1;
    check("hsr_out_valid", {31'b0, out_valid}, 32'd0);
    check("hsr_req_addr", imem_req_addr, 32'hFFFFFFFC);
    next_cycle();  // S_WAIT
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00000013;
    next_cycle();  // S_OUT
    #1;
    check("wrap_out_pc", out_pc, 32'hFFFFFFFC);
    out_ready = 1'b1;
    next_cycle();  // PC wraps to 0
    #1;
    check("wrap_req_addr", imem_req_addr, 32'h00000000);
    check("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    next_cycle();
    imem_req_ready = 1'b1;
    #1;
`ifdef IFU_MISALIGN_CHK_EN
    check("mis_fault", {31'b0, fetch_fault}, 32'd1);
    check("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    imem_resp_valid = 1'b1; imem_req_ready = 1'b1;
    next_cycle();
    #1;
    check("mis_fault_sticky", {31'b0, fetch_fault}, 32'd1);
    check("mis_req_valid2", {31'b0, imem_req_valid}, 32'd0);
    check("mis_out_valid", {31'b0, out_valid}, 32'd0);
`else
    check("mis_fault", {31'b0, fetch_fault}, 32'd0);
    check("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("mis_req_addr", imem_req_addr, 32'h80000100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the decoder/control unit.
- Owns the PC register and issues word reads to instruction memory over a valid/ready request channel with a separate response channel.
- Latches the returned instruction and presents it, with its PC and pre-sliced opcode/funct3/funct7 fields, to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards stale in-flight fetches.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h80000000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  fetch address; equals current PC.
- imem_resp_valid  input  1  response data valid, one cycle pulse per accepted request.
- imem_resp_data  input  32  returned instruction word.
- redirect_valid  input  1  execute-stage redirect, single-cycle pulse.
- redirect_pc  input  XLEN  redirect target.
- halt_req  input  1  level; suppresses new fetch requests while high.
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts the instruction.
- out_pc  output  XLEN  PC of the presented instruction.
- out_inst  output  32  full instruction word.
- out_opcode  output  7  out_inst[6:0].
- out_funct3  output  3  out_inst[14:12].
- out_funct7  output  1  out_inst[30].
- fetch_fault  output  1  misaligned-target fault; driven only with the optional feature, otherwise tied to 0.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=S_REQ, out_inst=32'h00000013 (NOP), out_pc=RESET_PC.
  - All valid outputs 0; fetch_fault=0.
  - imem_req_valid rises in the first cycle after rst deasserts.
- States:
  - S_REQ: imem_req_valid = !halt_req. Request accepted (valid & ready) -> S_WAIT.
  - S_WAIT: waiting for the response. imem_resp_valid -> latch out_inst=imem_resp_data, out_pc=pc -> S_OUT.
  - S_OUT: out_valid=1. out_valid & out_ready -> pc=pc+4 -> S_REQ.
  - S_DROP: waiting for a stale response. imem_resp_valid -> discard the data -> S_REQ.
- Redirect: highest priority. pc=redirect_pc in every state. Next state by current state:
  - S_REQ, no handshake this cycle: stay S_REQ; the new address is presented next cycle.
  - S_REQ, handshake in the same cycle: S_DROP, since the accepted request is stale.
  - S_WAIT, no response this cycle: S_DROP.
  - S_WAIT, response in the same cycle: discard the response -> S_REQ.
  - S_OUT: drop the held instruction -> S_REQ; out_valid falls next cycle and pc is not incremented.
  - S_DROP: stay S_DROP, or go to S_REQ if the response arrives in the same cycle.
- Output stability: while in S_OUT with out_ready=0, out_pc/out_inst/fields hold stable. Redirect is the only exception.
- imem_req_addr holds stable while imem_req_valid=1 and ready=0, unless a redirect occurs.
- Concurrency: at most one outstanding request; no new request is issued until the response is consumed or dropped.
- halt_req gates only imem_req_valid in S_REQ. It does not abort S_WAIT/S_OUT.
- PC arithmetic: XLEN-bit, wraps modulo 2^XLEN (32'hFFFFFFFC+4 -> 0).
- Latency: request-to-out_valid = memory latency + 1 cycle. Minimum issue interval is 3 cycles per instruction at zero memory wait.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until rst) and enters a terminal S_FAULT state. In S_FAULT imem_req_valid=0 and out_valid=0; any in-flight response is ignored.
- Undefined: fetch_fault is tied to 0. redirect_pc[1:0] is forced to 00 before loading pc.

Test Plan:
- Reset, zero-wait memory returning 32'h00100093 at 0x80000000 -> imem_req_addr=0x80000000; out_valid with out_inst=0x00100093, opcode=7'h13, funct3=0, funct7=0, out_pc=0x80000000. After accept, next request addr=0x80000004.
- out_ready held 0 for 5 cycles -> out_valid stays 1, out_pc/out_inst unchanged, no new imem request issued.
- redirect_valid with redirect_pc=0x80000100 while in S_WAIT; memory returns 2 cycles later -> that response is discarded, next request addr=0x80000100, no out_valid for the stale word.
- Redirect to 0x80000200 in the same cycle as out_valid&out_ready -> pc=0x80000200 (not +4); next request addr=0x80000200.
- halt_req=1 in S_REQ for 4 cycles -> imem_req_valid=0 throughout; deassert -> request at the unchanged PC.
- IFU_MISALIGN_CHK_EN defined, redirect_pc=0x80000102 -> fetch_fault=1 next cycle, no further requests until rst. Macro undefined -> next request addr=0x80000100.
